// File: rtl/redmule_pkg.sv
// Shared RedMulE types and helpers for the quantized-integer weight path.
// Holds the format enum plus the sub-beat helpers used by the unpack sequencer.
package redmule_pkg;

  localparam int unsigned DATA_W         = 256;
  localparam int unsigned QINT_MAX_BEATS = 4;

  // QINT_16 is a reserved encoding that the unpack sequencer does not support.
  typedef enum logic [1:0] {
    QINT_8  = 2'd0,
    QINT_4  = 2'd1,
    QINT_2  = 2'd2,
    QINT_16 = 2'd3
  } qint_fmt_e;

  typedef enum logic {
    UNP_IDLE = 1'b0,
    UNP_EMIT = 1'b1
  } unpack_state_e;

  function automatic logic [2:0] qint_nbeats(qint_fmt_e fmt);
    case (fmt)
      QINT_4:  return 3'd2;
      QINT_2:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic qint_supported(qint_fmt_e fmt);
    return (fmt == QINT_8) || (fmt == QINT_4) || (fmt == QINT_2);
  endfunction

endpackage

// File: rtl/redmule_qint_unpack_ctrl.sv
// Replays each packed weight word to the cast stage as 1, 2 or 4 right-aligned
// sub-beats, depending on the quantized format latched with the word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNP_IDLE | nothing held; stream_i.ready high, stream_o.valid low
// UNP_EMIT | word held; presenting sub-beat beat_q of nbeats
module redmule_qint_unpack_ctrl
  import redmule_pkg::*;
#(
  parameter int unsigned DW = DATA_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  qint_fmt_e       fmt_i,
  input  logic            stream_i_valid,
  output logic            stream_i_ready,
  input  logic [DW-1:0]   stream_i_data,
  input  logic [DW/8-1:0] stream_i_strb,
  output logic            stream_o_valid,
  input  logic            stream_o_ready,
  output logic [DW-1:0]   stream_o_data,
  output logic [DW/8-1:0] stream_o_strb,
  output logic            last_o,
  output logic            busy_o,
  output logic            unsupp_o,
  output qint_fmt_e       fmt_o
);

  localparam int unsigned SW = $clog2(DW) + 1;

  unpack_state_e   state_q, state_d;
  logic [DW-1:0]   word_q, word_d;
  logic [DW/8-1:0] strb_q, strb_d;
  qint_fmt_e       fmt_q, fmt_d;
  logic [1:0]      beat_q, beat_d;
  logic            unsupp_q, unsupp_d;

  logic [2:0]      nbeats;
  logic            emit;
  logic            last;
  logic            accept;
  logic [SW-1:0]   shamt;

  always_comb begin
    nbeats = qint_nbeats(fmt_q);
    emit   = (state_q == UNP_EMIT);
    last   = emit && ({1'b0, beat_q} == (nbeats - 3'd1));

    case (nbeats)
      3'd2:    shamt = beat_q[0] ? SW'(DW / 2) : '0;
      3'd4:    shamt = SW'(beat_q) * SW'(DW / 4);
      default: shamt = '0;
    endcase

    // Clear wins over an incoming word, so ready drops while it is asserted.
    stream_i_ready = !rst_i && !clear_i && (!emit || (last && stream_o_ready));
    accept         = stream_i_valid && stream_i_ready;

    stream_o_valid = emit;
    stream_o_data  = emit ? (word_q >> shamt) : '0;
    stream_o_strb  = emit ? ((nbeats == 3'd1) ? strb_q : '1) : '0;
    last_o         = last;
    busy_o         = emit;
    unsupp_o       = unsupp_q;
    fmt_o          = fmt_q;

    state_d  = state_q;
    word_d   = word_q;
    strb_d   = strb_q;
    fmt_d    = fmt_q;
    beat_d   = beat_q;
    unsupp_d = 1'b0;

    if (emit && stream_o_ready) begin
      if (!last) begin
        beat_d = beat_q + 2'd1;
      end else begin
        state_d = UNP_IDLE;
      end
    end

    // An accept on the last beat overrides the return to idle: no bubble.
    if (accept) begin
      state_d  = UNP_EMIT;
      word_d   = stream_i_data;
      strb_d   = stream_i_strb;
      fmt_d    = fmt_i;
      beat_d   = 2'd0;
      unsupp_d = !qint_supported(fmt_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q  <= UNP_IDLE;
      word_q   <= '0;
      strb_q   <= '0;
      fmt_q    <= QINT_8;
      beat_q   <= 2'd0;
      unsupp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      strb_q   <= strb_d;
      fmt_q    <= fmt_d;
      beat_q   <= beat_d;
      unsupp_q <= unsupp_d;
    end
  end

endmodule

// File: tb/tb_redmule_qint_unpack_ctrl.sv
// Randomized bench for redmule_qint_unpack_ctrl: a queue of expected sub-beats
// is built per accepted word and compared against the output every cycle.
module tb_redmule_qint_unpack_ctrl;
  import redmule_pkg::*;

  localparam int unsigned DW = 256;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            clear_i = 1'b0;
  qint_fmt_e       fmt_i = QINT_8;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [DW/8-1:0] in_strb = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [DW/8-1:0] out_strb;
  logic            last_o, busy_o, unsupp_o;
  qint_fmt_e       fmt_o;

  always #5 clk = ~clk;

  redmule_qint_unpack_ctrl #(.DW(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .fmt_i          (fmt_i),
    .stream_i_valid (in_valid),
    .stream_i_ready (in_ready),
    .stream_i_data  (in_data),
    .stream_i_strb  (in_strb),
    .stream_o_valid (out_valid),
    .stream_o_ready (out_ready),
    .stream_o_data  (out_data),
    .stream_o_strb  (out_strb),
    .last_o         (last_o),
    .busy_o         (busy_o),
    .unsupp_o       (unsupp_o),
    .fmt_o          (fmt_o)
  );

  typedef struct {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] s;
    logic            l;
  } beat_t;

  beat_t     exp_q[$];
  logic      exp_unsupp = 1'b0;
  qint_fmt_e exp_fmt = QINT_8;
  logic      acc_seen = 1'b0;
  int        n_checks = 0;
  int        n_errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sub-beat k of an n-way split is the k-th DW/n slice moved to bit 0.
  function automatic void push_word(input logic [DW-1:0] w, input logic [DW/8-1:0] s,
                                    input qint_fmt_e f);
    int    n;
    beat_t b;
    n = (f == QINT_8) ? 1 : (f == QINT_4) ? 2 : (f == QINT_2) ? 4 : 1;
    for (int k = 0; k < n; k++) begin
      b.d = w >> (k * (DW / n));
      b.s = (n == 1) ? s : '1;
      b.l = (k == n - 1);
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    logic exp_ready;
    exp_ready = !rst_i && !clear_i &&
                ((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
    chk("valid", DW'(out_valid), DW'(exp_q.size() > 0));
    chk("busy", DW'(busy_o), DW'(exp_q.size() > 0));
    chk("in_ready", DW'(in_ready), DW'(exp_ready));
    chk("unsupp", DW'(unsupp_o), DW'(exp_unsupp));
    chk("fmt_o", DW'(fmt_o), DW'(exp_fmt));
    if (exp_q.size() > 0) begin
      chk("data", out_data, exp_q[0].d);
      chk("strb", DW'(out_strb), DW'(exp_q[0].s));
      chk("last", DW'(last_o), DW'(exp_q[0].l));
    end

    if (rst_i || clear_i) begin
      exp_q.delete();
      exp_unsupp = 1'b0;
      exp_fmt    = QINT_8;
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      exp_unsupp = 1'b0;
      if (in_valid && in_ready) begin
        push_word(in_data, in_strb, fmt_i);
        exp_unsupp = !((fmt_i == QINT_8) || (fmt_i == QINT_4) || (fmt_i == QINT_2));
        exp_fmt    = fmt_i;
        acc_seen   = 1'b1;
      end
    end
  end

  function automatic qint_fmt_e pick_fmt(input int mode);
    if (mode < 0) return qint_fmt_e'(2'($urandom_range(0, 3)));
    return qint_fmt_e'(2'(mode));
  endfunction

  // rdy_pat=1 gives the 1,0,0 ready pattern; otherwise ready is random at p_ready%.
  task automatic run(input int cycles, input int p_valid, input int p_ready, input int fmt_mode,
                     input int p_clr, input int p_rst, input int rdy_pat);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (!in_valid || acc_seen) begin
        acc_seen = 1'b0;
        in_valid = ($urandom_range(0, 99) < p_valid);
        for (int i = 0; i < DW / 32; i++) in_data[i*32 +: 32] = $urandom;
        in_strb  = $urandom;
        fmt_i    = pick_fmt(fmt_mode);
      end else if (fmt_mode < 0) begin
        fmt_i = pick_fmt(fmt_mode);
      end
      out_ready = rdy_pat ? (c % 3 == 0) : ($urandom_range(0, 99) < p_ready);
      clear_i   = ($urandom_range(0, 99) < p_clr);
      rst_i     = ($urandom_range(0, 99) < p_rst);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_data", out_data, '0);
    chk("rst_strb", DW'(out_strb), '0);
    chk("rst_last", DW'(last_o), '0);
    chk("rst_ready", DW'(in_ready), DW'(1'b1));

    run(60, 100, 100, 0, 0, 0, 0);     // QINT_8 back-to-back
    run(60, 100, 100, 1, 0, 0, 0);     // QINT_4 back-to-back
    run(90, 100, 0, 2, 0, 0, 1);       // QINT_2 under 1,0,0 backpressure
    run(400, 70, 60, -1, 0, 0, 0);     // mixed formats, mid-word fmt changes
    run(200, 90, 90, 2, 8, 0, 0);      // clears landing mid-word
    run(200, 90, 90, 2, 0, 8, 0);      // resets landing mid-word
    run(600, 60, 50, -1, 2, 2, 0);     // everything at once

    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_i   = 1'b0;
    rst_i     = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
